// File: rtl/prod_accum.sv
// prod_accum: accumulates a frame of 1..16 unsigned products from the upstream
// multiplier and presents the frame sum with a valid/ready handshake.
// Frame length is sampled on the first accepted product of each frame.
module prod_accum #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [3:0]        len,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] product,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  sum,
  output logic [4:0]        count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A programmed length of zero stands for a full 16-product frame.
  function automatic logic [4:0] len_to_eff(input logic [3:0] l);
    logic [4:0] eff;
    if (l == 4'd0) begin
      eff = 5'd16;
    end else begin
      eff = {1'b0, l};
    end
    return eff;
  endfunction

  state_t            state_r, state_s;
  logic [ACC_W-1:0]  acc_r, acc_s;
  logic [ACC_W-1:0]  sum_r, sum_s;
  logic [4:0]        count_r, count_s;
  logic [4:0]        len_eff_r, len_eff_s;
  logic              out_valid_r;
  logic              in_ready_r;

  logic              xfer_s;
  logic [ACC_W-1:0]  product_ext_s;
  logic [ACC_W-1:0]  acc_sum_s;
  logic [4:0]        count_inc_s;
  logic [4:0]        len_new_s;

  assign xfer_s        = in_valid & in_ready_r;
  assign product_ext_s = {{(ACC_W-PROD_W){1'b0}}, product};
  assign acc_sum_s     = acc_r + product_ext_s;
  assign count_inc_s   = count_r + 5'd1;
  assign len_new_s     = len_to_eff(len);

  // Next-state and datapath update; clear outranks any transfer or handshake.
  always_comb begin
    state_s   = state_r;
    acc_s     = acc_r;
    sum_s     = sum_r;
    count_s   = count_r;
    len_eff_s = len_eff_r;
    if (clear) begin
      state_s = IDLE;
      acc_s   = {ACC_W{1'b0}};
      count_s = 5'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (xfer_s) begin
            len_eff_s = len_new_s;
            acc_s     = product_ext_s;
            count_s   = 5'd1;
            if (len_new_s == 5'd1) begin
              state_s = DONE;
              sum_s   = product_ext_s;
            end else begin
              state_s = ACC;
            end
          end else begin
            state_s = IDLE;
          end
        end
        ACC: begin
          if (xfer_s) begin
            acc_s   = acc_sum_s;
            count_s = count_inc_s;
            if (count_inc_s == len_eff_r) begin
              state_s = DONE;
              sum_s   = acc_sum_s;
            end else begin
              state_s = ACC;
            end
          end else begin
            state_s = ACC;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_s = IDLE;
            acc_s   = {ACC_W{1'b0}};
            count_s = 5'd0;
          end else begin
            state_s = DONE;
          end
        end
        default: begin
          state_s = IDLE;
          acc_s   = {ACC_W{1'b0}};
          count_s = 5'd0;
        end
      endcase
    end
  end

  // State and output registers; handshake flags are derived from the next state
  // so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= {ACC_W{1'b0}};
      sum_r       <= {ACC_W{1'b0}};
      count_r     <= 5'd0;
      len_eff_r   <= 5'd16;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      sum_r       <= sum_s;
      count_r     <= count_s;
      len_eff_r   <= len_eff_s;
      out_valid_r <= (state_s == DONE);
      in_ready_r  <= (state_s != DONE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign count     = count_r;

endmodule
